pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register for the in-order core. It generalises the fixed fetch-to-decode register.
- Carries PC, instruction and commit-trace info between any two stages, using a valid/ready handshake.
- Supports synchronous flush (bubble) and stall.
- An optional second (skid) entry lets in_ready be cut from out_ready while keeping full throughput.

Parameters:
- PC_W, 64, PC width
- INSTR_W, 32, instruction width
- INFO_W, 161, commit-trace info width
- SKID, 1, 1 = two-entry skid buffer (in_ready independent of out_ready); 0 = single-entry register with ready passthrough

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  bubble: discard all held and incoming entries
- stall  in  1  freeze stage: no accept, no emit
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  upstream PC
- in_instr  in  INSTR_W  upstream instruction
- in_info  in  INFO_W  upstream commit-trace info
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction
- out_info  out  INFO_W  head commit-trace info
- count  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Storage: main slot M (drives out_*) and skid slot S, each holding a valid bit plus payload. S exists only when SKID=1.
- Event definitions:
  - accept = in_valid & in_ready & ~flush
  - emit = out_valid & out_ready & ~stall
- Reset (rst=1 at posedge):
  - M and S invalid; all payload zero.
  - out_valid=0, out_* = 0, count=0.
  - in_ready=1 in the following cycle if stall=0.
- Priority: rst > flush > stall > normal operation.
- Flush:
  - Next cycle M and S are invalid with payloads zeroed; count=0.
  - An input offered during the flush cycle is dropped, even if in_ready=1.
  - Flush overrides stall.
- Stall:
  - in_ready=0, and out_ready is ignored.
  - All state holds; out_* stay stable.
- Zero-when-empty rule: out_pc, out_instr and out_info read 0 whenever out_valid=0. M payload is zeroed when M drains without refill.
- SKID=1:
  - in_ready = ~S.valid & ~stall; no combinational path from out_ready.
  - M empty, accept: M<=in.
  - M full, emit & accept: M<=in.
  - M full, ~emit, accept: S<=in (count becomes 2, in_ready drops next cycle).
  - S full, emit: M<=S, S cleared. Accept is impossible here because in_ready=0.
  - M full, emit, no accept, S empty: M cleared.
- SKID=0:
  - in_ready = (~M.valid | out_ready) & ~stall (combinational from out_ready).
  - accept: M<=in. emit without accept: M cleared.
- Latency and throughput:
  - Accept to out_valid: 1 cycle.
  - Sustained 1 entry/cycle in both modes with out_ready=1.
- Ordering: strict FIFO; an entry never duplicates or drops except on flush.
- Reset mid-transfer: held entries are lost; no partial payload is ever exposed.
- Assertions:
  - SKID=1: S.valid implies M.valid.
  - count equals M.valid + S.valid.

Decomposition:
- Shared package pipe_pkg holds:
  - PC_W, INSTR_W and COMMIT_INFO_W constants.
  - The typedef pipe_payload_t {pc, instr, info}.
  - A zero constant PIPE_PAYLOAD_NULL.
- One sub-module, pipe_slot: a valid bit plus payload register with synchronous load, clear and hold. It is instantiated as M and, when SKID=1, as S.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, count=0; in_ready=1 on the first cycle after rst deasserts.
- Streaming (both SKID values): 8 back-to-back entries, pc=0x80000000 stepping by 4, out_ready=1 -> each appears 1 cycle after accept, no gaps, in order.
- Backpressure (SKID=1): out_ready=0 while sending pc 0x80000000 then 0x80000004 -> count=2, in_ready=0, out_pc=0x80000000 held. Raise out_ready -> next cycle out_pc=0x80000004, count=1, in_ready=1.
- Flush: with count=2 and in_valid=1, pulse flush -> next cycle out_valid=0, out_* =0, count=0, offered entry absent from output.
- Stall: stall=1 with out_ready=1 and in_valid=1 for 3 cycles -> in_ready=0, outputs frozen, count unchanged. With flush=1 and stall=1 together -> stage empties next cycle.
- Passthrough (SKID=0): M full, toggle out_ready 0/1 -> in_ready follows out_ready in the same cycle; count never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and widths for inter-stage pipeline registers.
// A payload is the PC, instruction and commit-trace info that travel together between stages.
package pipe_pkg;

  localparam int PC_W          = 64;
  localparam int INSTR_W       = 32;
  localparam int COMMIT_INFO_W = 161;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic [INSTR_W-1:0]       instr;
    logic [COMMIT_INFO_W-1:0] info;
  } pipe_payload_t;

  localparam pipe_payload_t PIPE_PAYLOAD_NULL = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: valid bit plus payload register.
// Clear (or reset) wins over load and zeroes the payload, so an empty slot never shows stale data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = $bits(pipe_payload_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= din;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and stall.
// With SKID=1 a second entry absorbs one beat so in_ready depends only on local state.
module pipe_stage_skid #(
  parameter int PC_W    = pipe_pkg::PC_W,
  parameter int INSTR_W = pipe_pkg::INSTR_W,
  parameter int INFO_W  = pipe_pkg::COMMIT_INFO_W,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INFO_W-1:0]  in_info,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INFO_W-1:0]  out_info,
  output logic [1:0]         count
);

  localparam int W = PC_W + INSTR_W + INFO_W;

  logic [W-1:0] in_payload;
  logic [W-1:0] m_data;
  logic [W-1:0] m_din;
  logic         m_valid;
  logic         m_load;
  logic         m_clear;
  logic         s_valid;
  logic         accept;
  logic         emit;

  assign in_payload = {in_pc, in_instr, in_info};
  assign accept     = in_valid & in_ready & ~flush;
  assign emit       = m_valid & out_ready & ~stall;

  pipe_slot #(.W(W)) u_m (
    .clk   (clk),
    .rst   (rst),
    .clear (m_clear),
    .load  (m_load),
    .din   (m_din),
    .valid (m_valid),
    .data  (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic [W-1:0] s_data;
      logic         s_load;
      logic         s_clear;

      assign in_ready = ~s_valid & ~stall;

      always_comb begin
        // S always holds the older entry, so it has priority for refilling M.
        m_load  = ~flush & ((s_valid & emit) | (accept & (~m_valid | emit)));
        m_din   = s_valid ? s_data : in_payload;
        m_clear = flush | (emit & ~accept & ~s_valid);
        s_load  = ~flush & accept & m_valid & ~emit;
        s_clear = flush | (s_valid & emit);
      end

      pipe_slot #(.W(W)) u_s (
        .clk   (clk),
        .rst   (rst),
        .clear (s_clear),
        .load  (s_load),
        .din   (in_payload),
        .valid (s_valid),
        .data  (s_data)
      );
    end else begin : g_pass
      assign in_ready = (~m_valid | out_ready) & ~stall;
      assign s_valid  = 1'b0;

      always_comb begin
        m_load  = accept;
        m_din   = in_payload;
        m_clear = flush | (emit & ~accept);
      end
    end
  endgenerate

  assign out_valid                     = m_valid;
  assign {out_pc, out_instr, out_info} = m_data;
  assign count                         = {1'b0, m_valid} + {1'b0, s_valid};

  a_skid_behind_main: assert property (@(posedge clk) disable iff (rst) s_valid |-> m_valid);
  a_count_matches: assert property (@(posedge clk) disable iff (rst)
    count == ({1'b0, m_valid} + {1'b0, s_valid}));

endmodule
